// File: rtl/dmem_map_pkg.sv
// Shared address-map constants for the data-memory responder.
// Offsets, status bits, unmapped read pattern and region decode type.
package dmem_map_pkg;

  localparam logic [1:0] OFF_CON_TX     = 2'd0;
  localparam logic [1:0] OFF_CON_STATUS = 2'd1;
  localparam logic [1:0] OFF_TIMER_LO   = 2'd2;
  localparam logic [1:0] OFF_TIMER_HI   = 2'd3;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_CLR   = 2;

  localparam logic [31:0] UNMAPPED_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_MMIO,
    RGN_NONE
  } region_e;

  function automatic logic [31:0] lane_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Core-side data-memory bus plus console sink and fault status.
// master = core/environment side, slave = responder side.
interface dmem_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   dmem_addr;
  logic [DATA_WIDTH-1:0]   dmem_wdata;
  logic                    dmem_write;
  logic [DATA_WIDTH/8-1:0] dmem_wstrb;
  logic                    dmem_read;
  logic [DATA_WIDTH-1:0]   dmem_rdata;
  logic                    con_valid;
  logic [7:0]              con_data;
  logic                    con_ready;
  logic                    access_fault;
  logic [ADDR_WIDTH-1:0]   fault_addr;

  modport master (
    output dmem_addr,
    output dmem_wdata,
    output dmem_write,
    output dmem_wstrb,
    output dmem_read,
    output con_ready,
    input  dmem_rdata,
    input  con_valid,
    input  con_data,
    input  access_fault,
    input  fault_addr
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_write,
    input  dmem_wstrb,
    input  dmem_read,
    input  con_ready,
    output dmem_rdata,
    output con_valid,
    output con_data,
    output access_fault,
    output fault_addr
  );

endinterface

// File: rtl/con_fifo.sv
// Synchronous 8-bit console FIFO, power-of-two depth, no bypass.
// A push into a full FIFO succeeds only if a pop frees a slot that cycle.
module con_fifo #(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_data,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_drop,
  output logic [CW-1:0] o_count
);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);
  assign o_drop = i_push && o_full && !w_pop;

  // Head reads as zero while empty so the output is defined after reset.
  assign o_data = o_empty ? 8'h00 : r_mem[r_rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM, console/timer MMIO, sticky fault.
// Timer block present only when DMEM_RESPONDER_TIMER_EN is defined.
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    MEM_DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE       = 32'h1000_0000,
  parameter int                    CON_FIFO_DEPTH  = 8
) (
  input logic             clk,
  input logic             rst_n,
  dmem_responder_if.slave bus
);

  localparam int WIDX  = $clog2(MEM_DEPTH_WORDS);
  localparam int NLANE = DATA_WIDTH / 8;
  localparam int CW    = $clog2(CON_FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] RAM_BYTES =
    ADDR_WIDTH'(MEM_DEPTH_WORDS * 4);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH_WORDS];
  logic                  r_ovf;
  logic                  r_fault;
  logic [ADDR_WIDTH-1:0] r_faddr;

  region_e               w_region;
  logic [1:0]            w_off;
  logic [WIDX-1:0]       w_widx;
  logic                  w_ram_wr;
  logic                  w_mmio_wr;
  logic                  w_mmio_rd;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ovf_clr;
  logic                  w_fault;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic [7:0]            w_head;
  logic [CW-1:0]         w_count;
  logic [DATA_WIDTH-1:0] w_status;
  logic [DATA_WIDTH-1:0] w_tmr_lo;
  logic [DATA_WIDTH-1:0] w_tmr_hi;
  logic [DATA_WIDTH-1:0] w_mmio_rdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  always_comb begin
    w_region = RGN_NONE;
    if (bus.dmem_addr < RAM_BYTES) begin
      w_region = RGN_RAM;
    end else if (bus.dmem_addr[ADDR_WIDTH-1:4] ==
                 MMIO_BASE[ADDR_WIDTH-1:4]) begin
      w_region = RGN_MMIO;
    end
  end

  assign w_off  = bus.dmem_addr[3:2];
  assign w_widx = bus.dmem_addr[WIDX+1:2];

  assign w_ram_wr  = bus.dmem_write && (w_region == RGN_RAM);
  assign w_mmio_wr = bus.dmem_write && (w_region == RGN_MMIO);
  assign w_mmio_rd = bus.dmem_read && (w_region == RGN_MMIO);
  assign w_fault   = (bus.dmem_read || bus.dmem_write) &&
                     (w_region == RGN_NONE);

  assign w_push    = w_mmio_wr && (w_off == OFF_CON_TX) &&
                     bus.dmem_wstrb[0];
  assign w_pop     = bus.con_ready;
  assign w_ovf_clr = w_mmio_wr && (w_off == OFF_CON_STATUS) &&
                     bus.dmem_wstrb[0] && bus.dmem_wdata[STAT_CLR];

  con_fifo #(
    .DEPTH (CON_FIFO_DEPTH)
  ) u_con_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.dmem_wdata[7:0]),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_drop),
    .o_count (w_count)
  );

  assign bus.con_valid = !w_empty;
  assign bus.con_data  = w_head;

  always_ff @(posedge clk) begin
    if (w_ram_wr) begin
      for (int i = 0; i < NLANE; i++) begin
        if (bus.dmem_wstrb[i])
          r_mem[w_widx][8*i +: 8] <= bus.dmem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Only the first faulting address is kept; later faults just stay sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
      r_faddr <= '0;
    end else if (w_fault) begin
      r_fault <= 1'b1;
      if (!r_fault) r_faddr <= bus.dmem_addr;
    end
  end

  assign bus.access_fault = r_fault;
  assign bus.fault_addr   = r_faddr;

`ifdef DMEM_RESPONDER_TIMER_EN
  logic [63:0] r_timer;
  logic [31:0] r_snap;
  logic        w_tlo_wr;
  logic        w_thi_wr;
  logic        w_tlo_rd;

  assign w_tlo_wr = w_mmio_wr && (w_off == OFF_TIMER_LO);
  assign w_thi_wr = w_mmio_wr && (w_off == OFF_TIMER_HI);
  assign w_tlo_rd = w_mmio_rd && (w_off == OFF_TIMER_LO);

  // A load of either half suppresses that cycle's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
      r_snap  <= '0;
    end else begin
      if (w_tlo_wr) begin
        r_timer[31:0] <= lane_merge(r_timer[31:0],
          bus.dmem_wdata[31:0], bus.dmem_wstrb[3:0]);
      end else if (w_thi_wr) begin
        r_timer[63:32] <= lane_merge(r_timer[63:32],
          bus.dmem_wdata[31:0], bus.dmem_wstrb[3:0]);
      end else begin
        r_timer <= r_timer + 64'd1;
      end
      if (w_tlo_rd) r_snap <= r_timer[63:32];
    end
  end

  assign w_tmr_lo = DATA_WIDTH'(r_timer[31:0]);
  assign w_tmr_hi = DATA_WIDTH'(r_snap);
`else
  assign w_tmr_lo = '0;
  assign w_tmr_hi = '0;
`endif

  always_comb begin
    w_status = '0;
    w_status[STAT_EMPTY] = w_empty;
    w_status[STAT_FULL]  = w_full;
    w_status[STAT_OVF]   = r_ovf;
  end

  always_comb begin
    w_mmio_rdata = '0;
    unique case (w_off)
      OFF_CON_TX:     w_mmio_rdata = '0;
      OFF_CON_STATUS: w_mmio_rdata = w_status;
      OFF_TIMER_LO:   w_mmio_rdata = w_tmr_lo;
      OFF_TIMER_HI:   w_mmio_rdata = w_tmr_hi;
      default:        w_mmio_rdata = '0;
    endcase
  end

  // Combinational read sees pre-write state for same-cycle read+write.
  always_comb begin
    w_rdata = '0;
    if (bus.dmem_read) begin
      unique case (w_region)
        RGN_RAM:  w_rdata = r_mem[w_widx];
        RGN_MMIO: w_rdata = w_mmio_rdata;
        default:  w_rdata = DATA_WIDTH'(UNMAPPED_RDATA);
      endcase
    end
  end

  assign bus.dmem_rdata = w_rdata;

  assign w_unused = ^w_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: queue/array reference model
// compared every cycle, plus directed literal expectations.
module tb_dmem_responder;
  import dmem_map_pkg::*;

  localparam int          DEPTH = 8;
  localparam logic [31:0] MB    = 32'h1000_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();

  dmem_responder #(
    .ADDR_WIDTH      (32),
    .DATA_WIDTH      (32),
    .MEM_DEPTH_WORDS (1024),
    .MMIO_BASE       (MB),
    .CON_FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_mem [int];
  logic [7:0]  m_q [$];
  bit          m_ovf   = 0;
  bit          m_flt   = 0;
  logic [31:0] m_faddr = 0;
  logic [63:0] m_tmr   = 0;
  logic [31:0] m_snap  = 0;
  logic [63:0] m_next;
  logic [31:0] m_old;
  int          m_rg;

  function automatic int region(input logic [31:0] a);
    if (a < 32'd4096) return 0;
    if (a >= MB && a < MB + 32'd16) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o,
    input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rdata();
    int idx;
    if (!bus.dmem_read) return 32'h0;
    idx = int'(bus.dmem_addr >> 2);
    case (region(bus.dmem_addr))
      0: return m_mem.exists(idx) ? m_mem[idx] : 32'hx;
      1: case (bus.dmem_addr[3:2])
           2'd1: return {29'b0, m_ovf, m_q.size() == DEPTH,
                         m_q.size() == 0};
`ifdef DMEM_RESPONDER_TIMER_EN
           2'd2: return m_tmr[31:0];
           2'd3: return m_snap;
`endif
           default: return 32'h0;
         endcase
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_ovf = 0; m_flt = 0; m_faddr = 0; m_tmr = 0; m_snap = 0;
    end else begin
      m_rg = region(bus.dmem_addr);
      if (m_rg == 2 && (bus.dmem_read || bus.dmem_write)) begin
        if (!m_flt) m_faddr = bus.dmem_addr;
        m_flt = 1;
      end
      if (m_q.size() > 0 && bus.con_ready) void'(m_q.pop_front());
      m_next = m_tmr + 64'd1;
      if (bus.dmem_read && m_rg == 1 && bus.dmem_addr[3:2] == 2'd2)
        m_snap = m_tmr[63:32];
      if (bus.dmem_write && m_rg == 0) begin
        m_old = m_mem.exists(int'(bus.dmem_addr >> 2)) ?
                m_mem[int'(bus.dmem_addr >> 2)] : 32'hx;
        m_mem[int'(bus.dmem_addr >> 2)] =
          merge(m_old, bus.dmem_wdata, bus.dmem_wstrb);
      end
      if (bus.dmem_write && m_rg == 1) begin
        case (bus.dmem_addr[3:2])
          2'd0: if (bus.dmem_wstrb[0]) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus.dmem_wdata[7:0]);
            else m_ovf = 1;
          end
          2'd1: if (bus.dmem_wstrb[0] && bus.dmem_wdata[2]) m_ovf = 0;
          2'd2: m_next = {m_tmr[63:32],
            merge(m_tmr[31:0], bus.dmem_wdata, bus.dmem_wstrb)};
          default: m_next = {merge(m_tmr[63:32], bus.dmem_wdata,
            bus.dmem_wstrb), m_tmr[31:0]};
        endcase
      end
      m_tmr = m_next;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] e_rd;
  always @(negedge clk) begin
    e_rd = m_rdata();
    if (!$isunknown(e_rd)) chk("model_rdata", bus.dmem_rdata, e_rd);
    chk("model_con_valid", bus.con_valid, m_q.size() > 0);
    chk("model_con_data", bus.con_data,
        m_q.size() > 0 ? m_q[0] : 8'h00);
    chk("model_fault", bus.access_fault, m_flt);
    chk("model_faddr", bus.fault_addr, m_faddr);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [31:0] a, input logic [31:0] d,
    input logic w, input logic [3:0] s, input logic r);
    @(posedge clk); #1;
    bus.dmem_addr  = a;
    bus.dmem_wdata = d;
    bus.dmem_write = w;
    bus.dmem_wstrb = s;
    bus.dmem_read  = r;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    drive(a, d, 1'b1, s, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp,
                    input string nm);
    drive(a, 32'h0, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    chk(nm, bus.dmem_rdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(32'h0, 32'h0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    bus.dmem_addr = 0; bus.dmem_wdata = 0; bus.dmem_write = 0;
    bus.dmem_wstrb = 0; bus.dmem_read = 0; bus.con_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_con_valid", bus.con_valid, 0);
    chk("rst_con_data", bus.con_data, 0);
    chk("rst_fault", bus.access_fault, 0);
    chk("rst_faddr", bus.fault_addr, 0);
    chk("rst_rdata", bus.dmem_rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // RAM byte lanes and read-before-write
    wr(32'h40, 32'h0, 4'hF);
    wr(32'h40, 32'h1122_3344, 4'b0101);
    rd(32'h40, 32'h0022_0044, "ram_strb");
    drive(32'h40, 32'hAABB_CCDD, 1'b1, 4'hF, 1'b1);
    @(negedge clk);
    chk("ram_rw_old", bus.dmem_rdata, 32'h0022_0044);
    rd(32'h40, 32'hAABB_CCDD, "ram_after_rw");

    // console: three bytes, held then drained in order
    wr(MB, 32'h41, 4'h1);
    wr(MB, 32'h42, 4'h1);
    wr(MB, 32'h43, 4'h1);
    rd(MB + 4, 32'h0, "status_3");
    @(posedge clk); #1;
    bus.dmem_read = 0; bus.con_ready = 1;
    @(negedge clk); chk("con_b0", bus.con_data, 8'h41);
    @(negedge clk); chk("con_b1", bus.con_data, 8'h42);
    @(negedge clk); chk("con_b2", bus.con_data, 8'h43);
    @(negedge clk); chk("con_drained", bus.con_valid, 0);
    bus.con_ready = 0;

    // overflow: nine pushes into eight slots
    for (int i = 0; i < 9; i++) wr(MB, 32'h10 + i, 4'h1);
    rd(MB + 4, 32'h6, "status_ovf");
    wr(MB + 4, 32'h4, 4'h1);
    rd(MB + 4, 32'h2, "status_clr");

    // full FIFO: simultaneous push and pop
    drive(MB, 32'h99, 1'b1, 4'h1, 1'b0);
    bus.con_ready = 1;
    @(negedge clk); chk("full_head", bus.con_data, 8'h10);
    @(posedge clk); #1;
    bus.con_ready = 0; bus.dmem_write = 0;
    bus.dmem_addr = MB + 4; bus.dmem_read = 1;
    @(negedge clk);
    chk("pushpop_status", bus.dmem_rdata, 32'h2);
    chk("pushpop_head", bus.con_data, 8'h11);
    @(posedge clk); #1;
    bus.dmem_read = 0; bus.con_ready = 1;
    repeat (9) @(posedge clk);
    @(negedge clk); chk("drain_all", bus.con_valid, 0);
    bus.con_ready = 0;

`ifdef DMEM_RESPONDER_TIMER_EN
    wr(MB + 12, 32'h0, 4'hF);
    wr(MB + 8, 32'hFFFF_FFFE, 4'hF);
    idle(2);
    rd(MB + 8, 32'h0, "timer_lo");
    rd(MB + 12, 32'h1, "timer_hi_snap");
`else
    wr(MB + 8, 32'h5, 4'hF);
    rd(MB + 8, 32'h0, "notimer_lo");
    rd(MB + 12, 32'h0, "notimer_hi");
`endif
    chk("no_fault_yet", bus.access_fault, 0);

    // fault capture and boundaries
    rd(32'h2000_0000, 32'hDEAD_BEEF, "unmapped_rd");
    @(negedge clk);
    chk("fault_set", bus.access_fault, 1);
    chk("fault_addr", bus.fault_addr, 32'h2000_0000);
    wr(32'h3000_0004, 32'h1234, 4'hF);
    idle(1);
    @(negedge clk);
    chk("fault_keep", bus.fault_addr, 32'h2000_0000);
    wr(32'hFFC, 32'hCAFE_F00D, 4'hF);
    rd(32'hFFC, 32'hCAFE_F00D, "ram_last");
    rd(32'h1000, 32'hDEAD_BEEF, "ram_end");
    rd(MB + 16, 32'hDEAD_BEEF, "mmio_end");
    rd(MB - 4, 32'hDEAD_BEEF, "mmio_below");

    // reset mid-operation
    wr(MB, 32'h55, 4'h1);
    wr(MB, 32'h66, 4'h1);
    idle(1);
    @(negedge clk); chk("pre_rst_valid", bus.con_valid, 1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.con_valid, 0);
    chk("mid_rst_fault", bus.access_fault, 0);
    chk("mid_rst_faddr", bus.fault_addr, 0);
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
    rd(32'h40, 32'hAABB_CCDD, "ram_survives_rst");
    rd(MB + 4, 32'h1, "status_after_rst");
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
